r_ram_to_verify: RTL and testbench

//  Reads a BYTES-long byte image (default 32 B = 256-bit digest H) out of the shared byte RAM.

---
 rtl/r_ram_to_verify.sv | 132 +++++++++++++
 tb/tb_r_ram_to_verify.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_ram_to_verify.sv
// ---------------------------------------------------------------------------
// r_ram_to_verify
//   Reads a BYTES-long byte image out of the shared byte RAM and reassembles
//   it into the flat vector H for the verify datapath. The RAM byte at
//   BASE_ADDR+0 ends up in the MSB byte of H. It uses the same start/end
//   level handshake as the verify-side RAM writer.
//
// Ports
//   sys_clk                in   1        clock, rising edge
//   sys_rst_n              in   1        asynchronous active-low reset
//   r_ram_to_verify_start  in   1        level request; starts when high and end low
//   ram_dout               in   8        RAM read data
//   address                out  15       RAM address (registered)
//   ena                    out  1        RAM read enable, one-cycle pulse per byte
//   H                      out  8*BYTES  assembled image, byte0 at [8*BYTES-1 -: 8]
//   busy                   out  1        high from transfer start until end is set
//   r_ram_to_verify_end    out  1        completion flag
// ---------------------------------------------------------------------------
module r_ram_to_verify #(
    parameter logic [14:0] BASE_ADDR  = 15'd0,
    parameter int unsigned BYTES      = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 r_ram_to_verify_start,
    input  logic [7:0]           ram_dout,
    output logic [14:0]          address,
    output logic                 ena,
    output logic [8*BYTES-1:0]   H,
    output logic                 busy,
    output logic                 r_ram_to_verify_end
);

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned H_W    = 8 * BYTES;
    localparam int unsigned IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned LAT_W  = $clog2(RD_LATENCY + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(RD_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [LAT_W-1:0]    lat_q;
    logic [ADDR_W-1:0]   address_q;
    logic                ena_q;
    logic [H_W-1:0]      h_q;
    logic                busy_q;
    logic                end_q;

    // Read data is valid on this edge: lat has counted the full RAM latency
    logic capture_c;
    // Capture of the final byte; this edge sets end
    logic complete_c;

    assign capture_c  = (state_q == S_WAIT) && (lat_q == LAT_MAX);
    assign complete_c = capture_c && (idx_q == LAST_IDX);

    // Transfer sequencer: issue one read, wait out the latency, shift the byte in
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            lat_q     <= '0;
            address_q <= BASE_ADDR;
            ena_q     <= 1'b0;
            h_q       <= '0;
            busy_q    <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // end must be clear so a held start cannot re-trigger
                    if (r_ram_to_verify_start && !end_q) begin
                        state_q   <= S_ISSUE;
                        busy_q    <= 1'b1;
                        idx_q     <= '0;
                        address_q <= BASE_ADDR;
                        ena_q     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    ena_q   <= 1'b0;
                    lat_q   <= LAT_W'(1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture_c) begin
                        // Shift left by one byte; the cast drops the old MSB byte
                        h_q <= H_W'({h_q, ram_dout});
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            idx_q   <= '0;
                        end else begin
                            idx_q     <= idx_q + IDX_W'(1);
                            address_q <= BASE_ADDR + ADDR_W'(idx_q) + ADDR_W'(1);
                            ena_q     <= 1'b1;
                            state_q   <= S_ISSUE;
                        end
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Completion wins over the clear caused by start being low
            if (complete_c) begin
                end_q <= 1'b1;
            end else if (!r_ram_to_verify_start) begin
                end_q <= 1'b0;
            end
        end
    end

    assign address             = address_q;
    assign ena                 = ena_q;
    assign H                   = h_q;
    assign busy                = busy_q;
    assign r_ram_to_verify_end = end_q;

endmodule

// File: tb/tb_r_ram_to_verify.sv
// ---------------------------------------------------------------------------
// tb_r_ram_to_verify
//   Three DUT instances with different BASE_ADDR / RD_LATENCY settings, each
//   with its own byte RAM and latency pipe. A transfer-level reference model
//   per instance predicts every output each cycle; a few literal checks pin
//   the model on known images and timings.
// ---------------------------------------------------------------------------
module tb_r_ram_to_verify;

    localparam int NI = 3;

    function automatic logic [14:0] base_of(int i);
        case (i)
            0:       return 15'h0000;
            1:       return 15'h0100;
            default: return 15'h7FF0;
        endcase
    endfunction

    function automatic int lat_of(int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start [NI];
    logic [7:0]   dout  [NI];
    logic [14:0]  addr  [NI];
    logic         ena   [NI];
    logic [255:0] h     [NI];
    logic         busy  [NI];
    logic         endf  [NI];

    logic [7:0]   mem [NI][32768];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(int inst, string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s inst%0d @%0t: got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gen_inst
        localparam logic [14:0] BASE = base_of(g);
        localparam int unsigned LAT  = lat_of(g);
        localparam int unsigned PER  = 1 + LAT;
        localparam int unsigned TOT  = 32 * PER;

        r_ram_to_verify #(
            .BASE_ADDR (BASE),
            .BYTES     (32),
            .RD_LATENCY(LAT)
        ) u_dut (
            .sys_clk              (clk),
            .sys_rst_n            (rst_n),
            .r_ram_to_verify_start(start[g]),
            .ram_dout             (dout[g]),
            .address              (addr[g]),
            .ena                  (ena[g]),
            .H                    (h[g]),
            .busy                 (busy[g]),
            .r_ram_to_verify_end  (endf[g])
        );

        // RAM read port: address sampled with ena, data appears LAT edges later
        logic [7:0] pipe [LAT];
        always @(posedge clk) begin
            if (ena[g]) pipe[0] <= mem[g][addr[g]];
            for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
        end
        assign dout[g] = pipe[LAT-1];

        // Image the transfer should deliver: byte k from BASE+k, first byte on top
        function automatic logic [255:0] image();
            logic [255:0] r;
            r = '0;
            for (int k = 0; k < 32; k++) r = {r[247:0], mem[g][BASE + 15'(k)]};
            return r;
        endfunction

        // Transfer-level model: m_j counts edges since the start-sample edge
        bit           m_active = 1'b0;
        bit           m_end    = 1'b0;
        int unsigned  m_j      = 0;
        logic [14:0]  m_addr   = BASE;
        logic [255:0] m_h      = '0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_active <= 1'b0;
                m_end    <= 1'b0;
                m_j      <= 0;
                m_addr   <= BASE;
                m_h      <= '0;
            end else begin
                if (m_active) begin
                    m_j <= m_j + 1;
                    if (m_j + 1 == TOT) begin
                        m_active <= 1'b0;
                        m_h      <= image();
                    end else if ((m_j + 1) % PER == 0) begin
                        m_addr <= BASE + 15'((m_j + 1) / PER);
                    end
                end else if (start[g] && !m_end) begin
                    m_active <= 1'b1;
                    m_j      <= 0;
                    m_addr   <= BASE;
                end
                if (m_active && (m_j + 1 == TOT)) m_end <= 1'b1;
                else if (!start[g])               m_end <= 1'b0;
            end
        end

        // Per-cycle comparison against the model
        always @(negedge clk) begin
            chk(g, "ena",  256'(ena[g]),  256'(m_active && (m_j % PER == 0)));
            chk(g, "busy", 256'(busy[g]), 256'(m_active));
            chk(g, "end",  256'(endf[g]), 256'(m_end));
            chk(g, "addr", 256'(addr[g]), 256'(m_addr));
            if (!m_active) chk(g, "H", h[g], m_h);
        end
    end

    task automatic fill(int i, int mode);
        for (int a = 0; a < 32768; a++) begin
            case (mode)
                0:       mem[i][a] = 8'(a);
                1:       mem[i][a] = 8'hA5;
                default: mem[i][a] = 8'($urandom);
            endcase
        end
    endtask

    int          meas_first  [NI];
    int          meas_pulses [NI];
    logic [14:0] meas_afirst [NI];
    logic [14:0] meas_alast  [NI];
    logic [14:0] meas_a16    [NI];

    task automatic meas_sample(int c);
        for (int i = 0; i < NI; i++) begin
            if (meas_first[i] < 0) begin
                if (ena[i]) begin
                    if (meas_pulses[i] == 0)  meas_afirst[i] = addr[i];
                    if (meas_pulses[i] == 16) meas_a16[i]    = addr[i];
                    meas_alast[i] = addr[i];
                    meas_pulses[i]++;
                end
                if (endf[i]) meas_first[i] = c;
            end
        end
    endtask

    // Call with start just driven at a negedge; the next posedge is edge 0
    task automatic measure();
        bit all_seen;
        for (int i = 0; i < NI; i++) begin
            meas_first[i]  = -1;
            meas_pulses[i] = 0;
            meas_afirst[i] = '1;
            meas_alast[i]  = '0;
            meas_a16[i]    = '1;
        end
        @(posedge clk); #1;
        meas_sample(0);
        all_seen = 1'b0;
        for (int c = 1; c <= 400 && !all_seen; c++) begin
            @(posedge clk); #1;
            meas_sample(c);
            all_seen = 1'b1;
            for (int i = 0; i < NI; i++) if (meas_first[i] < 0) all_seen = 1'b0;
        end
    endtask

    task automatic set_start(logic v);
        for (int i = 0; i < NI; i++) start[i] = v;
    endtask

    int cnt_a [NI];
    int cnt_b [NI];

    initial begin
        set_start(1'b0);
        fill(0, 0);
        fill(1, 1);
        fill(2, 0);
        repeat (3) @(negedge clk);

        // Reset values
        for (int i = 0; i < NI; i++) begin
            chk(i, "rst_addr", 256'(addr[i]), 256'(base_of(i)));
            chk(i, "rst_ena",  256'(ena[i]),  256'(0));
            chk(i, "rst_busy", 256'(busy[i]), 256'(0));
            chk(i, "rst_end",  256'(endf[i]), 256'(0));
            chk(i, "rst_H",    h[i],          256'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        // First transfer with start held high
        set_start(1'b1);
        measure();
        chk(0, "end_edge", 256'(meas_first[0]), 256'(64));
        chk(1, "end_edge", 256'(meas_first[1]), 256'(128));
        chk(2, "end_edge", 256'(meas_first[2]), 256'(96));
        for (int i = 0; i < NI; i++) chk(i, "pulses", 256'(meas_pulses[i]), 256'(32));
        chk(0, "H_lit", h[0], 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F);
        chk(1, "H_lit", h[1], {32{8'hA5}});
        chk(2, "H_lit", h[2], 256'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF000102030405060708090A0B0C0D0E0F);
        chk(1, "a_first", 256'(meas_afirst[1]), 256'(15'h0100));
        chk(1, "a_last",  256'(meas_alast[1]),  256'(15'h011F));
        chk(2, "a_byte16", 256'(meas_a16[2]),   256'(15'h0000));
        chk(2, "a_last",  256'(meas_alast[2]),  256'(15'h000F));

        // Start held after end: no new transfer, end stays high
        for (int i = 0; i < NI; i++) cnt_a[i] = 0;
        repeat (20) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) if (ena[i]) cnt_a[i]++;
        end
        for (int i = 0; i < NI; i++) begin
            chk(i, "held_ena", 256'(cnt_a[i]), 256'(0));
            chk(i, "held_end", 256'(endf[i]), 256'(1));
        end

        // Drop start for one cycle, then re-arm with a fresh random image
        @(negedge clk);
        set_start(1'b0);
        fill(0, 2);
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk(i, "end_clr", 256'(endf[i]), 256'(0));
        set_start(1'b1);
        measure();
        chk(0, "end_edge2", 256'(meas_first[0]), 256'(64));
        chk(1, "end_edge2", 256'(meas_first[1]), 256'(128));

        // One-cycle start pulse: full transfer, end high exactly one cycle
        @(negedge clk);
        set_start(1'b0);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int i = 0; i < NI; i++) begin cnt_a[i] = 0; cnt_b[i] = 0; end
        repeat (300) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                if (endf[i]) cnt_a[i]++;
                if (ena[i])  cnt_b[i]++;
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk(i, "pulse_end_len", 256'(cnt_a[i]), 256'(1));
            chk(i, "pulse_enas",    256'(cnt_b[i]), 256'(31));
        end

        // Reset asserted mid-transfer, between clock edges
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk(i, "arst_addr", 256'(addr[i]), 256'(base_of(i)));
            chk(i, "arst_ena",  256'(ena[i]),  256'(0));
            chk(i, "arst_busy", 256'(busy[i]), 256'(0));
            chk(i, "arst_end",  256'(endf[i]), 256'(0));
            chk(i, "arst_H",    h[i],          256'(0));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_start(1'b1);
        measure();
        for (int i = 0; i < NI; i++) begin
            chk(i, "post_rst_a0",  256'(meas_afirst[i]), 256'(base_of(i)));
            chk(i, "post_rst_enas", 256'(meas_pulses[i]), 256'(32));
        end

        // Random start activity; RAM bytes change only while an instance is idle
        repeat (1500) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                start[i] = ($urandom_range(0, 3) != 0);
                if (!busy[i] && !start[i])
                    mem[i][base_of(i) + 15'($urandom_range(0, 31))] = 8'($urandom);
            end
        end
        @(negedge clk);
        set_start(1'b0);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
